// File: rtl/chrono_tick_control.sv
// Chronometer front-end: button sync/debounce, IDLE/RUN/PAUSE control,
// and tick prescaler that drives the first counter stage.
//
// Ports:
//   qzt_clk        in   system clock, rising edge
//   reset          in   synchronous, active-high
//   btn_start_stop in   raw push-button, high = pressed
//   btn_clear      in   raw push-button, high = pressed
//   tick           out  count clock, one rise per DIV run cycles
//   clr_out        out  counter clear request, active-high
//   running        out  high in RUN
//   paused         out  high in PAUSE
module chrono_tick_control #(
    parameter int DIV      = 500000,
    parameter int DEBOUNCE = 500000
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_clear,
    output logic tick,
    output logic clr_out,
    output logic running,
    output logic paused
);

    localparam int CW = $clog2(DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF   = CW'(DIV / 2);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    // Bit 0 = start/stop, bit 1 = clear.
    logic [1:0]         btn_raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         level;
    logic [1:0]         level_d;
    logic [1:0][DW-1:0] stab;
    logic [1:0]         press;

    logic               ev_ss;
    logic               ev_clr;

    state_t             state;
    state_t             state_nxt;
    logic               clr_nxt;

    logic [CW-1:0]      div_cnt;
    logic [CW-1:0]      div_inc;

    assign btn_raw = {btn_clear, btn_start_stop};

    // Press event = rising edge of the debounced level.
    assign press  = level & ~level_d;
    assign ev_ss  = press[0];
    assign ev_clr = press[1];

    assign div_inc = div_cnt + CW'(1);

    // Synchronizers and debouncers. Any cycle where the synchronized
    // level agrees with the accepted level restarts the stability count.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            stab    <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    stab[i] <= '0;
                end else if (stab[i] == DB_MAX) begin
                    level[i] <= sync2[i];
                    stab[i]  <= '0;
                end else begin
                    stab[i] <= stab[i] + DW'(1);
                end
            end
        end
    end

    // Run control. In PAUSE a clear outranks start/stop; in IDLE both
    // may act together (start and clear the counters at once).
    always_comb begin
        state_nxt = state;
        clr_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ev_ss) begin
                    state_nxt = RUN;
                end
                if (ev_clr) begin
                    clr_nxt = 1'b1;
                end
            end
            RUN: begin
                if (ev_ss) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (ev_clr) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end else if (ev_ss) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs. The prescaler advances on every edge
    // that leaves a RUN cycle, so PAUSE cycles never count; entering IDLE
    // zeroes tick on the same edge clr_out rises.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_out <= 1'b1;
            running <= 1'b0;
            paused  <= 1'b0;
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_out <= clr_nxt;
            running <= (state_nxt == RUN);
            paused  <= (state_nxt == PAUSE);
            if (state_nxt == IDLE) begin
                div_cnt <= '0;
                tick    <= 1'b0;
            end else if (state == RUN) begin
                if (div_cnt == LAST) begin
                    div_cnt <= '0;
                    tick    <= 1'b1;
                end else begin
                    div_cnt <= div_inc;
                    if (div_inc == HALF) begin
                        tick <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/chrono_tick_control.md
# chrono_tick_control

Front-end control stage for the chronometer. It divides the quartz clock into a fixed-rate count tick and debounces the start/stop and clear buttons. A three-state run control (IDLE/RUN/PAUSE) gates the tick and issues clear pulses. `tick` drives the `clk_in` of the first chronometer counter stage, and `clr_out` drives the counters' `reset`.

## Interface
- `DIV`, default 500000: `qzt_clk` cycles per tick period (100 Hz at 50 MHz); must be ≥ 2.
- `DEBOUNCE`, default 500000: cycles a synchronized button level must hold before it is accepted (10 ms); must be ≥ 1.
- `qzt_clk`  in  1  the single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `btn_start_stop`  in  1  raw asynchronous push-button, high = pressed.
- `btn_clear`  in  1  raw asynchronous push-button, high = pressed.
- `tick`  out  1  count clock for downstream counters; one rising edge per counted period.
- `clr_out`  out  1  clear request for downstream counters, active-high.
- `running`  out  1  high in RUN.
- `paused`  out  1  high in PAUSE.

## Operation
- **Input synchronization:** each button passes through its own 2-FF synchronizer.
- **Debouncer (one per button):**
  - Holds a debounced level and a stability counter, width clog2(DEBOUNCE+1).
  - The counter increments while the synchronized level ≠ the debounced level.
  - It clears whenever the synchronized level equals the debounced level, so any glitch restarts the count.
  - When the counter reaches DEBOUNCE, the debounced level takes the synchronized value and the counter clears.
  - A press event is a one-cycle flag on the debounced level's 0→1 edge. Release produces no event.
- **FSM states:** IDLE, RUN, PAUSE. Transitions on press events:
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - PAUSE + start_stop → RUN.
  - PAUSE + clear → IDLE, with a clr_out pulse.
  - IDLE + clear → IDLE, with a clr_out pulse.
  - RUN + clear → ignored.
- **Simultaneous events in one cycle:**
  - In PAUSE, clear wins: go to IDLE and pulse clr_out.
  - In IDLE, go to RUN and pulse clr_out.
  - In RUN, start_stop acts and clear is dropped.
- **Prescaler:** `div_cnt`, width clog2(DIV), counts 0..DIV-1 and wraps, advancing only in RUN.
  - PAUSE: `div_cnt` and `tick` hold their values, so a partial period is preserved across pause.
  - IDLE: `div_cnt` = 0 and `tick` = 0.
- **Tick generation:** `tick` is registered.
  - It is set on the edge where `div_cnt` wraps DIV-1→0.
  - It is cleared on the edge where `div_cnt` becomes DIV/2 (integer division).
  - Result: high for DIV/2 cycles, period DIV.
- **Reset:** state = IDLE, `div_cnt` = 0, `tick` = 0, `clr_out` = 1, `running` = 0, `paused` = 0, synchronizers and debounced levels = 0, stability counters = 0.
- **Reset mid-operation:** aborts RUN/PAUSE immediately; the partial period is discarded.

## Timing
- All outputs are registered and update on the `qzt_clk` rising edge.
- **Button latency:** raw input first sampled high at edge k and held → debounced level rises at edge k+2+DEBOUNCE → FSM state, `running`/`paused` and `clr_out` update at edge k+3+DEBOUNCE.
- **First tick:** state becomes RUN at edge s → first `tick` rise at edge s+DIV, then every DIV edges.
- **Pause accounting:** counted run time excludes PAUSE cycles exactly. Total RUN cycles between consecutive `tick` rises = DIV.
- **clr_out timing:**
  - High for exactly one cycle per accepted clear.
  - Held high for every cycle `reset` is high; falls at the first edge after `reset` deasserts.
- **Downstream compatibility:** `tick` is never high in the same cycle as `clr_out`, because the IDLE forcing applies the same edge.

## Test plan
- **Reset:** DIV=10, DEBOUNCE=4; hold `reset` 3 cycles → `clr_out`=1 during reset, then 0; `tick`=`running`=`paused`=0; state IDLE.
- **Start:** `btn_start_stop` high from edge k → `running`=1 at edge k+7; `tick` rises at k+17, falls at k+22, rises again at k+27.
- **Bounce rejection:** `btn_clear` toggles every 2 cycles for 20 cycles, then stays low → no `clr_out` pulse, no state change.
- **Pause and resume:** RUN for 13 cycles, pause for 50 cycles, resume → `tick` frozen during PAUSE; next `tick` rise after 7 further RUN cycles.
- **Clear rules:**
  - Clear pressed in RUN → ignored.
  - Clear pressed in PAUSE → state IDLE, `clr_out` one-cycle pulse, `tick`=0, `div_cnt`=0.
- **Simultaneous press and reset mid-run:**
  - Both buttons' events land in the same cycle in PAUSE → IDLE plus `clr_out` pulse.
  - `reset` asserted in RUN with `tick`=1 → `tick`=0 and `running`=0 on the next edge.
